// File: rtl/valid_ready_source_pkg.sv
// Shared definitions for the valid/ready stream source and its matching sink checker.
// Holds the FSM state encoding and the default field widths.
package valid_ready_source_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_LEN_W = 8;
   localparam int DEFAULT_GAP_W = 4;

endpackage

// File: rtl/valid_ready_source_if.sv
// Valid/ready stream bundle: the master drives valid_down/data_down, the slave drives ready_down.
interface valid_ready_source_if
   import valid_ready_source_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             valid_down;
   logic             ready_down;
   logic [WIDTH-1:0] data_down;

   modport master (
      output valid_down,
      output data_down,
      input  ready_down
   );

   modport slave (
      input  valid_down,
      input  data_down,
      output ready_down
   );

endinterface

// File: rtl/valid_ready_gap_counter.sv
// Loadable down-counter with a zero flag; times the idle cycles between beats.
module valid_ready_gap_counter
   import valid_ready_source_pkg::*;
#(
   parameter int GAP_W = DEFAULT_GAP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [GAP_W-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [GAP_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - GAP_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/valid_ready_source.sv
// Burst generator at the producing end of a valid/ready stream: emits incrementing
// words with optional idle gaps, holding valid/data stable under backpressure.
module valid_ready_source
   import valid_ready_source_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LEN_W = DEFAULT_LEN_W,
   parameter int GAP_W = DEFAULT_GAP_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     burst_len,
   input  logic [GAP_W-1:0]     gap,
   input  logic [WIDTH-1:0]     data_init,
   valid_ready_source_if.master stream,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_W-1:0]     beat_count
);

   state_t           state;
   state_t           state_next;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_next;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_next;
   logic [GAP_W-1:0] gap_load;
   logic [WIDTH-1:0] word_next;
   logic [LEN_W-1:0] count_next;
   logic             xfer;
   logic             gap_start;
   logic             gap_dec;
   logic             gap_zero;

   assign xfer     = stream.valid_down && stream.ready_down;
   // The counter is loaded with gap-1 so that GAP lasts exactly gap cycles.
   assign gap_load = gap_q - GAP_W'(1);

   valid_ready_gap_counter #(
      .GAP_W (GAP_W)
   ) u_gap_counter (
      .clk        (clk),
      .rst        (rst),
      .load       (gap_start),
      .load_value (gap_load),
      .dec        (gap_dec),
      .zero       (gap_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= ST_IDLE;
         len_q            <= '0;
         gap_q            <= '0;
         beat_count       <= '0;
         stream.valid_down <= 1'b0;
         stream.data_down  <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= state_next;
         len_q            <= len_next;
         gap_q            <= gap_next;
         beat_count       <= count_next;
         stream.valid_down <= (state_next == ST_SEND);
         stream.data_down  <= word_next;
         busy             <= (state_next != ST_IDLE);
         done             <= (state_next == ST_DONE);
      end
   end

   always_comb begin
      state_next = state;
      len_next   = len_q;
      gap_next   = gap_q;
      word_next  = stream.data_down;
      count_next = beat_count;
      gap_start  = 1'b0;
      gap_dec    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               len_next   = burst_len;
               gap_next   = gap;
               word_next  = data_init;
               count_next = '0;
               state_next = (burst_len == '0) ? ST_DONE : ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               count_next = beat_count + LEN_W'(1);
               word_next  = stream.data_down + WIDTH'(1);
               if (count_next == len_q) begin
                  state_next = ST_DONE;
               end else if (gap_q != '0) begin
                  state_next = ST_GAP;
                  gap_start  = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_zero) begin
               state_next = ST_SEND;
            end else begin
               gap_dec = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_valid_ready_source.sv
// Scoreboard bench for valid_ready_source: stimulus queues expected beats, a negedge
// monitor pops and compares every transfer, gap length and done pulse.
module tb_valid_ready_source;

   localparam int WIDTH = 4;
   localparam int LEN_W = 8;
   localparam int GAP_W = 4;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               gap;
      bit               first;
      bit               last;
      bit               empty;
      int               len;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic [GAP_W-1:0] gap;
   logic [WIDTH-1:0] data_init;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] beat_count;

   valid_ready_source_if #(.WIDTH(WIDTH)) stream_if ();

   valid_ready_source #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W),
      .GAP_W (GAP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .burst_len  (burst_len),
      .gap        (gap),
      .data_init  (data_init),
      .stream     (stream_if),
      .busy       (busy),
      .done       (done),
      .beat_count (beat_count)
   );

   beat_t            sb[$];
   int               n_vec = 0;
   int               n_err = 0;
   bit               mon_en = 1'b0;
   int               ready_mode = 0;

   bit               prev_valid = 1'b0;
   bit               prev_ready = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   bit               prev_last = 1'b0;
   int               last_len = 0;
   int               low_cnt = 0;

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic fail_check(input string name, input string why);
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s: %s", name, why);
   endtask

   // One clock step; ready_down is refreshed here so a single process drives it.
   task automatic step();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       stream_if.ready_down = 1'b1;
         1:       stream_if.ready_down = 1'($urandom_range(0, 1));
         default: stream_if.ready_down = 1'b0;
      endcase
   endtask

   task automatic apply_stimulus(input int len, input int gp, input logic [WIDTH-1:0] init);
      int    wait_cyc;
      beat_t item;
      wait_cyc = 0;
      while (busy && wait_cyc < 1000) begin
         step();
         wait_cyc++;
      end
      if (busy) fail_check("idle_wait", "source never returned to idle");
      if (len == 0) begin
         item = '{data: '0, gap: 0, first: 1'b1, last: 1'b0, empty: 1'b1, len: 0};
         sb.push_back(item);
      end
      for (int i = 0; i < len; i++) begin
         item.data  = init + WIDTH'(i);
         item.gap   = gp;
         item.first = (i == 0);
         item.last  = (i == len - 1);
         item.empty = 1'b0;
         item.len   = len;
         sb.push_back(item);
      end
      burst_len = LEN_W'(len);
      gap       = GAP_W'(gp);
      data_init = init;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int cyc;
      cyc = 0;
      while ((sb.size() != 0 || busy) && cyc < budget) begin
         step();
         cyc++;
      end
      if (cyc >= budget) begin
         fail_check("burst_timeout", $sformatf("%0d beats still pending", sb.size()));
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      beat_t item;
      bit    xfer_last;
      bit    xfer;
      xfer_last = 1'b0;
      xfer      = stream_if.valid_down && stream_if.ready_down;
      if (mon_en) begin
         if (prev_valid && !prev_ready) begin
            check_output("hold_valid", 32'(stream_if.valid_down), 32'd1);
            check_output("hold_data", 32'(stream_if.data_down), 32'(prev_data));
         end
         if (done) begin
            if (prev_last) begin
               check_output("done_count", 32'(beat_count), 32'(last_len));
            end else if (sb.size() != 0 && sb[0].empty) begin
               void'(sb.pop_front());
               check_output("empty_count", 32'(beat_count), 32'd0);
            end else begin
               fail_check("spurious_done", "done without a completed burst");
            end
         end else if (prev_last) begin
            fail_check("missing_done", "no done after last beat");
         end
         if (!stream_if.valid_down) low_cnt++;
         if (xfer) begin
            if (sb.size() == 0 || sb[0].empty) begin
               fail_check("unexpected_beat", $sformatf("data %0h", stream_if.data_down));
            end else begin
               item = sb.pop_front();
               check_output("beat_data", 32'(stream_if.data_down), 32'(item.data));
               if (!item.first) check_output("gap_cycles", 32'(low_cnt), 32'(item.gap));
               xfer_last = item.last;
               if (item.last) last_len = item.len;
            end
            low_cnt = 0;
         end
      end
      prev_valid = stream_if.valid_down;
      prev_ready = stream_if.ready_down;
      prev_data  = stream_if.data_down;
      prev_last  = xfer_last;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst                  = 1'b0;
      start                = 1'b0;
      burst_len            = '0;
      gap                  = '0;
      data_init            = '0;
      stream_if.ready_down = 1'b1;
      step();
      step();
      check_output("rst_valid", 32'(stream_if.valid_down), 32'd0);
      check_output("rst_data", 32'(stream_if.data_down), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_count", 32'(beat_count), 32'd0);
      rst = 1'b1;
      step();

      $display("[TB] reset mid-burst");
      apply_stimulus(5, 0, 4'h3);
      step();
      step();
      check_output("pre_rst_count", 32'(beat_count), 32'd2);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_output("midrst_valid", 32'(stream_if.valid_down), 32'd0);
      check_output("midrst_busy", 32'(busy), 32'd0);
      check_output("midrst_count", 32'(beat_count), 32'd0);
      check_output("midrst_done", 32'(done), 32'd0);
      step();
      check_output("midrst_done2", 32'(done), 32'd0);
      sb.delete();
      mon_en = 1'b1;
      apply_stimulus(1, 0, 4'hA);
      wait_idle(100);

      $display("[TB] back-to-back");
      apply_stimulus(8, 0, 4'h1);
      wait_idle(100);
      check_output("b2b_count", 32'(beat_count), 32'd8);

      $display("[TB] backpressure");
      ready_mode = 2;
      stream_if.ready_down = 1'b0;
      apply_stimulus(3, 0, 4'h6);
      for (int i = 0; i < 4; i++) begin
         check_output("bp_valid", 32'(stream_if.valid_down), 32'd1);
         check_output("bp_data", 32'(stream_if.data_down), 32'h6);
         step();
      end
      ready_mode = 0;
      stream_if.ready_down = 1'b1;
      wait_idle(100);

      $display("[TB] gap and wrap");
      apply_stimulus(4, 2, 4'hE);
      wait_idle(100);

      $display("[TB] zero length");
      apply_stimulus(0, 0, 4'h5);
      check_output("zero_done", 32'(done), 32'd1);
      check_output("zero_valid", 32'(stream_if.valid_down), 32'd0);
      wait_idle(100);

      $display("[TB] ignored start");
      apply_stimulus(4, 1, 4'h9);
      step();
      step();
      start     = 1'b1;
      burst_len = 8'd7;
      data_init = 4'h0;
      step();
      start     = 1'b0;
      wait_idle(100);

      $display("[TB] random ready, long burst");
      ready_mode = 1;
      apply_stimulus(200, 0, 4'($urandom));
      wait_idle(2000);

      for (int b = 0; b < 6; b++) begin
         apply_stimulus(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 4'($urandom));
         wait_idle(500);
      end
      ready_mode = 0;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
